// File: rtl/clf_head_arbiter_if.sv
// Signal bundle between clf_head_arbiter (master) and the requesters, shared head and response consumer (slave).
// A response transfers on a rising clk edge with resp_valid && resp_ready; resp_valid and resp_* hold until that edge.
interface clf_head_arbiter_if #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_CLASSES = 4
) ();
   localparam int SEL_W = $clog2(NUM_REQ);
   localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

   logic [NUM_REQ-1:0]                      req;
   logic [NUM_REQ-1:0]                      grant;
   logic [SEL_W-1:0]                        head_sel;
   logic                                    head_start;
   logic                                    head_out_valid;
   logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0]  head_logits_in;
   logic                                    resp_valid;
   logic                                    resp_ready;
   logic [SEL_W-1:0]                        resp_id;
   logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0]  resp_logits;
   logic [CLS_W-1:0]                        resp_class;
   logic                                    resp_err;
   logic                                    busy;

   modport master (
      input  req, head_out_valid, head_logits_in, resp_ready,
      output grant, head_sel, head_start, resp_valid, resp_id,
             resp_logits, resp_class, resp_err, busy
   );

   modport slave (
      output req, head_out_valid, head_logits_in, resp_ready,
      input  grant, head_sel, head_start, resp_valid, resp_id,
             resp_logits, resp_class, resp_err, busy
   );
endinterface

// File: rtl/clf_head_arbiter.sv
// Round-robin arbiter sharing one classification head among NUM_REQ requesters, with timeout and response channel.
// Define CLF_ARB_ARGMAX_EN to add the sequential argmax scan that fills resp_class; otherwise resp_class is 0.
module clf_head_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_CLASSES = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic               clk,
   input  logic               rst,
   clf_head_arbiter_if.master bus,
   output logic [2:0]         o_dbg_state
);
   localparam int SEL_W = $clog2(NUM_REQ);
   localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_WAIT   = 3'd2,
`ifdef CLF_ARB_ARGMAX_EN
      S_ARGMAX = 3'd3,
`endif
      S_RESP   = 3'd4
   } state_t;

   state_t                                 r_state;
   state_t                                 w_state_next;
   logic [NUM_REQ-1:0]                     r_grant;
   logic [SEL_W-1:0]                       r_sel;
   logic [SEL_W-1:0]                       r_rr_ptr;
   logic [CNT_W-1:0]                       r_cnt;
   logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] r_logits;
   logic                                   r_err;
   logic [SEL_W-1:0]                       w_winner;
   logic                                   w_found;
   logic                                   w_take;
   logic                                   w_capture;
   logic                                   w_timeout;
   logic                                   w_handshake;

   function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return SEL_W'(s);
   endfunction

   // First requesting index at or after the round-robin pointer, with wrap.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_found && bus.req[wrap_idx(r_rr_ptr, i)]) begin
            w_found  = 1'b1;
            w_winner = wrap_idx(r_rr_ptr, i);
         end
      end
   end

`ifdef CLF_ARB_ARGMAX_EN
   logic [CLS_W-1:0] r_class;
   logic [CLS_W-1:0] r_scan_idx;
   logic             w_scan_last;
   logic             w_better;

   assign w_scan_last = (r_scan_idx == CLS_W'(NUM_CLASSES - 1));
   // Strictly greater only, so ties keep the lowest index.
   assign w_better    = $signed(r_logits[r_scan_idx]) > $signed(r_logits[r_class]);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_take       = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      w_handshake  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_take       = 1'b1;
               w_state_next = S_START;
            end
         end
         S_START: w_state_next = S_WAIT;
         S_WAIT: begin
            // A result arriving in the timeout cycle still counts as a normal result.
            if (bus.head_out_valid) begin
               w_capture    = 1'b1;
`ifdef CLF_ARB_ARGMAX_EN
               w_state_next = S_ARGMAX;
`else
               w_state_next = S_RESP;
`endif
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_timeout    = 1'b1;
               w_state_next = S_RESP;
            end
         end
`ifdef CLF_ARB_ARGMAX_EN
         S_ARGMAX: begin
            if (w_scan_last) w_state_next = S_RESP;
         end
`endif
         S_RESP: begin
            if (bus.resp_ready) begin
               w_handshake  = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant  <= '0;
         r_sel    <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
         r_logits <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_take) begin
            r_grant <= NUM_REQ'(1) << w_winner;
            r_sel   <= w_winner;
         end
         if (r_state == S_START)     r_cnt <= '0;
         else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
         if (w_capture) begin
            r_logits <= bus.head_logits_in;
            r_err    <= 1'b0;
         end
         if (w_timeout) begin
            r_logits <= '0;
            r_err    <= 1'b1;
         end
         if (w_handshake) begin
            r_grant  <= '0;
            r_err    <= 1'b0;
            r_rr_ptr <= wrap_idx(r_sel, 1);
         end
      end
   end

`ifdef CLF_ARB_ARGMAX_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_class    <= '0;
         r_scan_idx <= '0;
      end else if (w_capture || w_timeout) begin
         r_class    <= '0;
         r_scan_idx <= '0;
      end else if (r_state == S_ARGMAX) begin
         if (w_better)     r_class    <= r_scan_idx;
         if (!w_scan_last) r_scan_idx <= r_scan_idx + CLS_W'(1);
      end
   end

   assign bus.resp_class = r_class;
`else
   assign bus.resp_class = '0;
`endif

   assign bus.grant       = r_grant;
   assign bus.head_sel    = r_sel;
   assign bus.head_start  = (r_state == S_START);
   assign bus.resp_valid  = (r_state == S_RESP);
   assign bus.resp_id     = r_sel;
   assign bus.resp_logits = r_logits;
   assign bus.resp_err    = r_err;
   assign bus.busy        = (r_state != S_IDLE);
   assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_clf_head_arbiter.sv
// Directed bench for clf_head_arbiter: head model, expected-response queue, immediate-assertion checks.
module tb_clf_head_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int DATA_WIDTH  = 16;
   localparam int NUM_CLASSES = 4;
   localparam int TIMEOUT     = 64;
   localparam int SEL_W       = 2;
   localparam int CLS_W       = 2;
   localparam int LW          = NUM_CLASSES * DATA_WIDTH;
   localparam int RW          = SEL_W + 1 + CLS_W + LW;
`ifdef CLF_ARB_ARGMAX_EN
   localparam int EXP_LAT     = 1 + NUM_CLASSES;
`else
   localparam int EXP_LAT     = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;
   int         n_chk  = 0;
   int         n_fail = 0;
   logic [RW-1:0] exp_q[$];

   clf_head_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .NUM_CLASSES(NUM_CLASSES)) bus_if ();

   clf_head_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .NUM_CLASSES(NUM_CLASSES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if), .o_dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog");
   end

   // helpers and driver tasks
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic logic [LW-1:0] mk_logits(input int c0, input int c1, input int c2, input int c3);
      return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   function automatic int model_argmax(input logic [LW-1:0] l);
      int best = 0;
      for (int i = 1; i < NUM_CLASSES; i++)
         if ($signed(l[i*DATA_WIDTH +: DATA_WIDTH]) > $signed(l[best*DATA_WIDTH +: DATA_WIDTH])) best = i;
      return best;
   endfunction

   task automatic push_exp(input int id, input logic err, input int cls, input logic [LW-1:0] logits);
      exp_q.push_back({SEL_W'(id), err, CLS_W'(cls), logits});
   endtask

   task automatic check_resp(input string tag);
      logic [RW-1:0] e;
      chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk({tag, "_id"},     bus_if.resp_id,     e[RW-1 -: SEL_W]);
      chk({tag, "_err"},    bus_if.resp_err,    e[LW+CLS_W]);
      chk({tag, "_class"},  bus_if.resp_class,  e[LW +: CLS_W]);
      chk({tag, "_logits"}, bus_if.resp_logits, e[LW-1:0]);
   endtask

   task automatic start_job(input logic [3:0] mask, input int id, input string tag);
      bus_if.req = mask;
      tick();
      chk({tag, "_start"}, bus_if.head_start, 1'b1);
      chk({tag, "_grant"}, bus_if.grant, 4'b0001 << id);
      chk({tag, "_sel"},   bus_if.head_sel, id);
   endtask

   // Head model: result strobe in the d-th WAIT cycle, then wait for the response.
   task automatic head_and_resp(input int d, input logic [LW-1:0] logits, input int id, input string tag);
      int lat;
      int cls;
      for (int i = 0; i < d; i++) begin
         tick();
         if (i == 0) chk({tag, "_start_pulse"}, bus_if.head_start, 1'b0);
      end
      bus_if.head_out_valid = 1'b1;
      bus_if.head_logits_in = logits;
`ifdef CLF_ARB_ARGMAX_EN
      cls = model_argmax(logits);
`else
      cls = 0;
`endif
      push_exp(id, 1'b0, cls, logits);
      lat = 0;
      while (lat < 200) begin
         tick();
         bus_if.head_out_valid = 1'b0;
         lat++;
         if (bus_if.resp_valid) break;
      end
      chk({tag, "_lat"}, lat, EXP_LAT);
      check_resp(tag);
   endtask

   task automatic handshake(input logic [3:0] next_req, input string tag);
      bus_if.resp_ready = 1'b1;
      bus_if.req        = next_req;
      tick();
      bus_if.resp_ready = 1'b0;
      chk({tag, "_hs_valid"}, bus_if.resp_valid, 1'b0);
      chk({tag, "_hs_busy"},  bus_if.busy,       1'b0);
      chk({tag, "_hs_grant"}, bus_if.grant,      4'b0000);
   endtask

   // directed sequence
   initial begin
      int lat;
      int cnt;
      int fair_ids[5];
      logic [LW-1:0] lg;
      fair_ids = '{0, 1, 2, 3, 0};

      rst                   = 1'b1;
      bus_if.req            = '0;
      bus_if.head_out_valid = 1'b0;
      bus_if.head_logits_in = '0;
      bus_if.resp_ready     = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_grant",  bus_if.grant,       4'b0000);
      chk("rst_sel",    bus_if.head_sel,    0);
      chk("rst_start",  bus_if.head_start,  1'b0);
      chk("rst_valid",  bus_if.resp_valid,  1'b0);
      chk("rst_id",     bus_if.resp_id,     0);
      chk("rst_logits", bus_if.resp_logits, 0);
      chk("rst_class",  bus_if.resp_class,  0);
      chk("rst_err",    bus_if.resp_err,    1'b0);
      chk("rst_busy",   bus_if.busy,        1'b0);

      // spurious head result in IDLE
      bus_if.head_out_valid = 1'b1;
      bus_if.head_logits_in = mk_logits(1, 2, 3, 4);
      tick();
      bus_if.head_out_valid = 1'b0;
      cnt = 0;
      repeat (10) begin
         tick();
         if (bus_if.resp_valid || bus_if.busy) cnt++;
      end
      chk("idle_spurious", cnt, 0);

      // round-robin with all requests held
      for (int j = 0; j < 5; j++) begin
         lg = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
         start_job(4'b1111, fair_ids[j], "rr");
         head_and_resp($urandom_range(1, 8), lg, fair_ids[j], "rr");
         handshake((j == 4) ? 4'b0000 : 4'b1111, "rr");
      end

      // single requester with tied maxima
      start_job(4'b0010, 1, "single");
      head_and_resp(2, mk_logits(100, -5, 300, 300), 1, "single");
      handshake(4'b0000, "single");

      // timeout
      start_job(4'b0100, 2, "tmo");
      push_exp(2, 1'b1, 0, '0);
      lat = 0;
      while (lat < 300) begin
         tick();
         lat++;
         if (bus_if.resp_valid) break;
      end
      chk("tmo_lat", lat, TIMEOUT + 1);
      check_resp("tmo");
      handshake(4'b0000, "tmo");

      // backpressure: ready low 10 cycles, another request arrives meanwhile
      start_job(4'b1000, 3, "bp");
      head_and_resp(3, mk_logits(-1, -2, -3, -4), 3, "bp");
      bus_if.req = 4'b1001;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus_if.resp_valid !== 1'b1 || bus_if.resp_class !== 2'd0 ||
             bus_if.resp_logits !== mk_logits(-1, -2, -3, -4) ||
             bus_if.grant !== 4'b1000 || bus_if.head_start !== 1'b0) cnt++;
      end
      chk("bp_stable", cnt, 0);
      handshake(4'b0000, "bp");

      // result strobe in the same cycle the timeout would fire
      start_job(4'b0001, 0, "sim");
      head_and_resp(TIMEOUT, mk_logits(5, 7, -9, 7), 0, "sim");
      handshake(4'b0000, "sim");

      // reset in the middle of WAIT
      start_job(4'b0010, 1, "midrst");
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("midrst_busy",  bus_if.busy,       1'b0);
      chk("midrst_grant", bus_if.grant,      4'b0000);
      chk("midrst_sel",   bus_if.head_sel,   0);
      chk("midrst_valid", bus_if.resp_valid, 1'b0);
      tick();
      rst        = 1'b0;
      bus_if.req = 4'b0000;
      tick();
      bus_if.head_out_valid = 1'b1;
      bus_if.head_logits_in = mk_logits(9, 9, 9, 9);
      tick();
      bus_if.head_out_valid = 1'b0;
      cnt = 0;
      repeat (20) begin
         tick();
         if (bus_if.resp_valid || bus_if.busy) cnt++;
      end
      chk("midrst_no_resp", cnt, 0);

      // pointer back at 0 after reset
      start_job(4'b0011, 0, "post");
      head_and_resp(4, mk_logits(-7, 2, 2, -3), 0, "post");
      handshake(4'b0000, "post");

      chk("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
